// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared states, error codes and defaults for the UART command
//               frame controller.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_CHK  = 2'b01;
    localparam logic [1:0] ERR_ADDR = 2'b10;
    localparam logic [1:0] ERR_TOUT = 2'b11;

    localparam logic [7:0] c_sync_default = 8'hAA;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_timeout.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_timeout
// Description : Loadable down-counter; o_tc is high once T_CYC-1 enabled
//               cycles have elapsed since the last load.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_timeout #(
    parameter int T_CYC = 12000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam int                 c_width = $clog2(T_CYC + 1);
    localparam logic [c_width-1:0] c_load  = c_width'(T_CYC - 1);

    logic [c_width-1:0] r_cnt;

    // Holds at zero so a terminal count is never skipped by wrap-around.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_load;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Sequences received bytes through SYNC/ADDR/DATA/CHK frames and
//               writes DATA into a small configuration register bank.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int         G_FREQ_CLK   = 12000000,
    parameter int         G_TIMEOUT_US = 1000,
    parameter int         G_NREGS      = 4,
    parameter logic [7:0] G_SYNC       = c_sync_default
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dat_ready,
    input  logic [7:0]             dat_i,
    output logic [8*G_NREGS-1:0]   regs_o,
    output logic                   wr_stb,
    output logic [3:0]             wr_addr,
    output logic [7:0]             wr_data,
    output logic                   err_stb,
    output logic [1:0]             err_code,
    output logic                   busy,
    output logic [7:0]             frame_cnt
);

    localparam int c_t_cyc = (G_FREQ_CLK / 1000000) * G_TIMEOUT_US;

    state_t     r_state;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic [7:0] r_bank [G_NREGS];
    logic       r_wr_stb;
    logic [3:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic       r_err_stb;
    logic [1:0] r_err_code;
    logic [7:0] r_frame_cnt;

    logic w_tc;
    logic w_tout;
    logic w_sum_ok;
    logic w_addr_ok;

    uart_cmd_timeout #(
        .T_CYC (c_t_cyc)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .i_load (dat_ready),
        .i_en   (r_state != S_IDLE),
        .o_tc   (w_tc)
    );

    // A byte arriving on the terminal-count cycle takes precedence.
    assign w_tout    = w_tc && (r_state != S_IDLE) && !dat_ready;
    assign w_sum_ok  = (dat_i == (r_addr ^ r_data));
    assign w_addr_ok = ({24'd0, r_addr} < 32'(G_NREGS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_err_stb   <= 1'b0;
            r_err_code  <= '0;
            r_frame_cnt <= '0;
            for (int k = 0; k < G_NREGS; k++) begin
                r_bank[k] <= '0;
            end
        end else begin
            r_wr_stb  <= 1'b0;
            r_err_stb <= 1'b0;
            if (w_tout) begin
                r_err_stb  <= 1'b1;
                r_err_code <= ERR_TOUT;
                r_state    <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (dat_ready && (dat_i == G_SYNC)) begin
                            r_state <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        if (dat_ready) begin
                            r_addr  <= dat_i;
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (dat_ready) begin
                            r_data  <= dat_i;
                            r_state <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        if (dat_ready) begin
                            r_state <= S_IDLE;
                            if (!w_sum_ok) begin
                                r_err_stb  <= 1'b1;
                                r_err_code <= ERR_CHK;
                            end else if (!w_addr_ok) begin
                                r_err_stb  <= 1'b1;
                                r_err_code <= ERR_ADDR;
                            end else begin
                                r_wr_stb    <= 1'b1;
                                r_wr_addr   <= r_addr[3:0];
                                r_wr_data   <= r_data;
                                r_frame_cnt <= r_frame_cnt + 8'd1;
                                for (int k = 0; k < G_NREGS; k++) begin
                                    if (r_addr == 8'(k)) begin
                                        r_bank[k] <= r_data;
                                    end
                                end
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    for (genvar k = 0; k < G_NREGS; k++) begin : g_pack
        assign regs_o[8*k +: 8] = r_bank[k];
    end

    assign wr_stb    = r_wr_stb;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign err_stb   = r_err_stb;
    assign err_code  = r_err_code;
    assign busy      = (r_state != S_IDLE);
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Scoreboard bench for uart_cmd_ctrl frame handling.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int c_t_cyc = 12000;
    localparam int c_nregs = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dat_ready = 1'b0;
    logic [7:0]  dat_i = 8'h00;
    logic [31:0] regs_o;
    logic        wr_stb;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        err_stb;
    logic [1:0]  err_code;
    logic        busy;
    logic [7:0]  frame_cnt;

    uart_cmd_ctrl #(
        .G_FREQ_CLK   (12000000),
        .G_TIMEOUT_US (1000),
        .G_NREGS      (c_nregs),
        .G_SYNC       (8'hAA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dat_ready (dat_ready),
        .dat_i     (dat_i),
        .regs_o    (regs_o),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .err_stb   (err_stb),
        .err_code  (err_code),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [1:0]  code;
        logic [3:0]  waddr;
        logic [7:0]  wdata;
        logic [7:0]  cnt;
        logic [31:0] regs;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;

    logic [31:0] m_regs  = '0;
    logic [7:0]  m_cnt   = '0;
    logic [3:0]  m_waddr = '0;
    logic [7:0]  m_wdata = '0;
    logic [1:0]  m_ecode = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Every strobe must match the oldest outstanding expectation, on its due cycle.
    always @(negedge clk) begin
        if (mon_en && (wr_stb === 1'b1 || err_stb === 1'b1)) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_strobe", {62'd0, wr_stb, err_stb}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("latency",   cyc,       mon_e.due);
                check_eq("wr_stb",    wr_stb,    mon_e.is_wr);
                check_eq("err_stb",   err_stb,   !mon_e.is_wr);
                check_eq("err_code",  err_code,  mon_e.code);
                check_eq("wr_addr",   wr_addr,   mon_e.waddr);
                check_eq("wr_data",   wr_data,   mon_e.wdata);
                check_eq("regs_o",    regs_o,    mon_e.regs);
                check_eq("frame_cnt", frame_cnt, mon_e.cnt);
                check_eq("busy_end",  busy,      1'b0);
            end
        end
    end

    task automatic snapshot_push(input bit is_wr, input int due);
        exp_t e;
        e.is_wr = is_wr;
        e.code  = m_ecode;
        e.waddr = m_waddr;
        e.wdata = m_wdata;
        e.cnt   = m_cnt;
        e.regs  = m_regs;
        e.due   = due;
        sb.push_back(e);
    endtask

    // Called at the negedge on which the CHK byte is presented.
    task automatic push_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        int idx;
        if (c != (a ^ d)) begin
            m_ecode = 2'b01;
            snapshot_push(1'b0, cyc + 1);
        end else if (int'(a) >= c_nregs) begin
            m_ecode = 2'b10;
            snapshot_push(1'b0, cyc + 1);
        end else begin
            idx = int'(a);
            m_regs[8*idx +: 8] = d;
            m_cnt   = m_cnt + 8'd1;
            m_waddr = a[3:0];
            m_wdata = d;
            snapshot_push(1'b1, cyc + 1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        dat_i     = b;
        dat_ready = 1'b1;
        @(negedge clk);
        dat_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'hAA);
        send_byte(a);
        send_byte(d);
        push_frame(a, d, c);
        send_byte(c);
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check_eq("drain", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] a;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        check_eq("rst_regs",      regs_o,    32'd0);
        check_eq("rst_wr_stb",    wr_stb,    1'b0);
        check_eq("rst_err_stb",   err_stb,   1'b0);
        check_eq("rst_busy",      busy,      1'b0);
        check_eq("rst_frame_cnt", frame_cnt, 8'd0);
        check_eq("rst_err_code",  err_code,  2'b00);
        check_eq("rst_wr_addr",   wr_addr,   4'd0);
        check_eq("rst_wr_data",   wr_data,   8'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Good write, with busy observed mid-frame.
        send_byte(8'hAA);
        check_eq("busy_mid", busy, 1'b1);
        send_byte(8'h02);
        send_byte(8'h5A);
        push_frame(8'h02, 8'h5A, 8'h58);
        send_byte(8'h58);
        wait_drain(10);

        send_frame(8'h01, 8'h33, 8'h00);
        wait_drain(10);
        send_frame(8'h07, 8'h10, 8'h17);
        wait_drain(10);

        // Inter-byte timeout, then a normal frame.
        send_byte(8'hAA);
        m_ecode = 2'b11;
        snapshot_push(1'b0, cyc + 1 + c_t_cyc);
        send_byte(8'h01);
        wait_drain(c_t_cyc + 50);
        check_eq("tout_busy", busy, 1'b0);
        send_frame(8'h00, 8'hFF, 8'hFF);
        wait_drain(10);

        // Junk before SYNC is ignored; SYNC value is ordinary data inside a frame.
        send_byte(8'h55);
        send_byte(8'h13);
        send_frame(8'h03, 8'hAA, 8'hA9);
        wait_drain(10);

        // Byte arriving on the terminal-count cycle wins over the timeout.
        send_byte(8'hAA);
        repeat (c_t_cyc - 1) @(negedge clk);
        send_byte(8'h01);
        send_byte(8'hCC);
        push_frame(8'h01, 8'hCC, 8'hCD);
        send_byte(8'hCD);
        wait_drain(10);

        // Mid-frame reset aborts silently.
        send_byte(8'hAA);
        send_byte(8'h00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_regs = '0; m_cnt = '0; m_waddr = '0; m_wdata = '0; m_ecode = '0;
        check_eq("mrst_busy",      busy,      1'b0);
        check_eq("mrst_regs",      regs_o,    32'd0);
        check_eq("mrst_frame_cnt", frame_cnt, 8'd0);
        check_eq("mrst_err_code",  err_code,  2'b00);
        send_byte(8'hFF);
        send_byte(8'hFF);
        repeat (3) @(negedge clk);
        check_eq("post_rst_regs", regs_o, 32'd0);
        check_eq("post_rst_busy", busy,   1'b0);

        for (int i = 0; i < 256; i++) begin
            a = 8'($urandom_range(0, c_nregs - 1));
            d = 8'($urandom);
            send_frame(a, d, a ^ d);
        end
        wait_drain(20);
        check_eq("cnt_wrap", frame_cnt, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Frame controller that sits downstream of the UART receiver. It takes the receiver's byte stream (one-cycle byte-valid strobe plus 8-bit data) and sequences it through a 4-byte command frame: SYNC, ADDR, DATA, CHK.
- Each valid frame writes DATA into a small register bank whose outputs configure downstream blocks (LEDs, motor setpoints).
- Malformed frames, bad addresses and inter-byte timeouts are flagged and discarded.

Parameters:
- G_FREQ_CLK, 12000000, system clock frequency in Hz.
- G_TIMEOUT_US, 1000, maximum gap between bytes of one frame, in microseconds.
- G_NREGS, 4, number of 8-bit registers in the bank (1..16).
- G_SYNC, 8'hAA, frame start byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- dat_ready  in  1  one-cycle strobe from the UART receiver: dat_i is valid
- dat_i  in  8  received byte
- regs_o  out  8*G_NREGS  register bank; register k is bits [8k+7:8k]
- wr_stb  out  1  one-cycle pulse when a register is written
- wr_addr  out  4  address of the last write
- wr_data  out  8  data of the last write
- err_stb  out  1  one-cycle pulse on frame error
- err_code  out  2  01 = checksum, 10 = bad address, 11 = timeout; holds the last error
- busy  out  1  high while a frame is in progress (state other than S_IDLE)
- frame_cnt  out  8  count of good frames, wraps 255->0

Behaviour:
- Clocking and reset: single clock domain, synchronous active-high reset. On rst: state S_IDLE; regs_o, wr_addr, wr_data, err_code, frame_cnt all 0; wr_stb, err_stb, busy 0; timeout counter cleared.
- States and transitions. A byte is consumed only in a cycle with dat_ready=1.
  - S_IDLE: a byte equal to G_SYNC -> S_ADDR. Any other byte is ignored, with no error.
  - S_ADDR: latch the byte into addr_q -> S_DATA.
  - S_DATA: latch the byte into data_q -> S_CHK.
  - S_CHK: compare the byte with addr_q XOR data_q, then go to S_IDLE in all cases.
    - Mismatch: err_code=01, err_stb pulse.
    - Match but addr_q >= G_NREGS: err_code=10, err_stb pulse.
    - Otherwise: write regs_o[addr_q]=data_q, set wr_addr and wr_data, pulse wr_stb, frame_cnt+1.
  - The checksum check has priority over the address check.
- Latency: wr_stb, regs_o update and err_stb are all registered. They are asserted in the cycle after the dat_ready that carries the CHK byte, and each pulse lasts exactly one cycle.
- No back-pressure: every dat_ready is consumed in the cycle it arrives.
- Timeout:
  - T_CYC = (G_FREQ_CLK/1000000)*G_TIMEOUT_US; counter width is clog2(T_CYC+1).
  - The counter runs only in S_ADDR, S_DATA and S_CHK. It clears on entry to those states and on every consumed byte.
  - When it reaches T_CYC-1 without a byte: err_code=11, err_stb pulse, go to S_IDLE.
  - Default T_CYC = 12000 cycles, well above one 115200-baud byte time (~1042 cycles).
- Simultaneous events:
  - dat_ready in the same cycle the counter hits terminal count: the byte wins, is processed normally, and the counter clears.
  - A SYNC-valued byte received in S_ADDR/S_DATA/S_CHK is treated as ordinary data; there is no resynchronisation inside a frame.
- Failed frames never modify regs_o or frame_cnt.
- A rst asserted mid-frame aborts the frame and produces no error pulse.
- frame_cnt wraps from 255 to 0 silently.
- Address width: addr_q is 8 bits; only the low 4 bits are driven on wr_addr. The bound check uses the full 8 bits.

Decomposition:
- Package uart_cmd_pkg holds:
  - the state enum (S_IDLE, S_ADDR, S_DATA, S_CHK);
  - the error code constants (ERR_CHK=2'b01, ERR_ADDR=2'b10, ERR_TOUT=2'b11);
  - the default SYNC value.
- One natural sub-module, uart_cmd_timeout: loadable down-counter with clear input and terminal-count output, parameterised by T_CYC.
- The FSM, register bank and counters stay in the top.

Test Plan:
- Reset, then bytes AA 02 5A 58 -> one cycle after the last dat_ready: wr_stb=1, wr_addr=2, regs_o[23:16]=8'h5A, frame_cnt=1, err_stb=0, busy=0.
- Bytes AA 01 33 00 (bad checksum) -> err_stb=1, err_code=01, regs_o unchanged, frame_cnt unchanged.
- Bytes AA 07 10 17 with G_NREGS=4 -> err_stb=1, err_code=10, no wr_stb.
- Bytes AA 01, then no byte for 12000 cycles -> err_stb in cycle ~12000 after the 01 byte, err_code=11, busy=0. A following full frame AA 00 FF FF writes regs_o[7:0]=8'hFF.
- Bytes 55 13 AA 03 AA A9 -> the leading 55 and 13 are ignored; the SYNC 0xAA used as data is accepted, so regs_o[31:24]=8'hAA.
- rst asserted after AA 00 -> busy=0, regs_o=0; the following bytes FF FF produce no write and no error. Separately, 256 good frames -> frame_cnt returns to 0.
